// File: rtl/octal_to_binary_encoder_if.sv
// rtl/octal_to_binary_encoder_if.sv - sample/result bundle for the octal-to-binary encoder
//
// Signals:
//   in_valid   qualifies in for this cycle
//   in[7:0]    one-hot octal line select, bit k means digit k
//   clr_err    clears err_sticky
//   out[2:0]   registered binary code of the selected line
//   out_valid  registered copy of in_valid
//   err_none   registered flag: last valid sample was all zero
//   err_multi  registered flag: last valid sample had more than one bit set
//   err_sticky set by any valid error sample, held until clr_err or reset
// Modports: master drives samples (testbench/upstream), slave is the encoder.
interface octal_to_binary_encoder_if;
    logic       in_valid;
    logic [7:0] in;
    logic       clr_err;
    logic [2:0] out;
    logic       out_valid;
    logic       err_none;
    logic       err_multi;
    logic       err_sticky;

    modport master (
        output in_valid, in, clr_err,
        input  out, out_valid, err_none, err_multi, err_sticky
    );

    modport slave (
        input  in_valid, in, clr_err,
        output out, out_valid, err_none, err_multi, err_sticky
    );
endinterface

// File: rtl/octal_to_binary_encoder.sv
// rtl/octal_to_binary_encoder.sv - registered one-hot octal to 3-bit binary encoder with error flags
//
// Ports:
//   clk    rising-edge clock for all state
//   rst_n  synchronous active-low reset
//   bus    octal_to_binary_encoder_if.slave (in_valid, in, clr_err -> out, out_valid,
//          err_none, err_multi, err_sticky)
// Parameter:
//   HOLD_ON_ERR  1: out keeps its previous value on an error sample; 0: error samples give 0
// Build option:
//   OCTAL_TO_BINARY_PRIORITY_EN  when defined, a multi-hot sample encodes the highest set bit;
//                                otherwise it is treated like the all-zero error case for out.
// Every output is a flop; latency from a valid sample to its result is one cycle.
module octal_to_binary_encoder #(
    parameter bit HOLD_ON_ERR = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    octal_to_binary_encoder_if.slave    bus
);

    logic       is_zero;
    logic       is_multi;
    logic [2:0] hi_idx;
    logic [2:0] out_nxt;

    always_comb begin
        is_zero  = (bus.in == 8'h00);
        // Clearing the lowest set bit leaves something only if two or more bits were set.
        is_multi = ((bus.in & (bus.in - 8'd1)) != 8'h00);

        // Highest set bit; for a one-hot sample this is simply its index.
        hi_idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (bus.in[k]) begin
                hi_idx = 3'(k);
            end
        end

        if (is_zero) begin
            out_nxt = HOLD_ON_ERR ? bus.out : 3'd0;
        end else if (is_multi) begin
`ifdef OCTAL_TO_BINARY_PRIORITY_EN
            out_nxt = hi_idx;
`else
            out_nxt = HOLD_ON_ERR ? bus.out : 3'd0;
`endif
        end else begin
            out_nxt = hi_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out        <= 3'd0;
            bus.out_valid  <= 1'b0;
            bus.err_none   <= 1'b0;
            bus.err_multi  <= 1'b0;
            bus.err_sticky <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.out       <= out_nxt;
                bus.err_none  <= is_zero;
                bus.err_multi <= is_multi;
            end else begin
                bus.err_none  <= 1'b0;
                bus.err_multi <= 1'b0;
            end
            // A fresh error sample wins over a simultaneous clear.
            if (bus.in_valid && (is_zero || is_multi)) begin
                bus.err_sticky <= 1'b1;
            end else if (bus.clr_err) begin
                bus.err_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_octal_to_binary_encoder.sv
// tb/tb_octal_to_binary_encoder.sv - directed self-checking bench for octal_to_binary_encoder
module tb_octal_to_binary_encoder;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    octal_to_binary_encoder_if if0 ();
    octal_to_binary_encoder_if if1 ();

    octal_to_binary_encoder #(.HOLD_ON_ERR(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    octal_to_binary_encoder #(.HOLD_ON_ERR(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one sample to both instances, then sample 1 time unit after the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic c);
        if0.in_valid = v; if0.in = d; if0.clr_err = c;
        if1.in_valid = v; if1.in = d; if1.clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check0(input string tag, input logic [2:0] o, input logic ov,
                          input logic en, input logic em, input logic es);
        check({tag, ".out"},        8'(if0.out),        8'(o));
        check({tag, ".out_valid"},  8'(if0.out_valid),  8'(ov));
        check({tag, ".err_none"},   8'(if0.err_none),   8'(en));
        check({tag, ".err_multi"},  8'(if0.err_multi),  8'(em));
        check({tag, ".err_sticky"}, 8'(if0.err_sticky), 8'(es));
    endtask

    logic [7:0] sweep_in  [9];
    logic [2:0] sweep_out [9];
    logic [2:0] multi_out0;
    logic [2:0] multi_out1;

    initial begin
        tests = 0;
        fails = 0;
        sweep_in  = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        sweep_out = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`ifdef OCTAL_TO_BINARY_PRIORITY_EN
        multi_out0 = 3'd5;
        multi_out1 = 3'd5;
`else
        multi_out0 = 3'd0;
        multi_out1 = 3'd7;
`endif

        // Reset with an aggressive sample present: everything stays clear.
        rst_n = 1'b0;
        step(1'b1, 8'hFF, 1'b1);
        check0("rst1", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b1);
        check0("rst2", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst2.hold_out", 8'(if1.out), 8'd0);
        rst_n = 1'b1;
        step(1'b0, 8'hFF, 1'b0);
        check0("idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // One-hot sweep, back to back.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, sweep_in[i], 1'b0);
            check0($sformatf("sweep%0d", i), sweep_out[i], 1'b1, (i == 0), 1'b0, 1'b1);
            check($sformatf("sweep%0d.hold_out", i), 8'(if1.out), 8'(sweep_out[i]));
        end

        // Multi-hot.
        step(1'b1, 8'h24, 1'b0);
        check0("multi", multi_out0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("multi.hold_out", 8'(if1.out), 8'(multi_out1));

        // Valid gating: out holds, flags drop.
        step(1'b0, 8'h08, 1'b0);
        check0("gate_off", multi_out0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h08, 1'b0);
        check0("gate_on", 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);

        // Sticky set/clear and set-wins.
        step(1'b1, 8'h00, 1'b0);
        check0("zero", 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h01, 1'b1);
        check0("clr", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b1);
        check0("set_wins", 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check0("sticky_hold", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check0("clr_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // HOLD_ON_ERR=1 keeps the last good code on a zero sample.
        step(1'b1, 8'h40, 1'b0);
        check("hold_a.out", 8'(if1.out), 8'd6);
        step(1'b1, 8'h00, 1'b0);
        check("hold_b.out", 8'(if1.out), 8'd6);
        check("hold_b.err_none", 8'(if1.err_none), 8'd1);
        check("hold_b.dut0_out", 8'(if0.out), 8'd0);

        // Mid-run reset drops the sample presented with it.
        step(1'b1, 8'h80, 1'b0);
        check("pre_rst.out", 8'(if0.out), 8'd7);
        rst_n = 1'b0;
        step(1'b1, 8'h00, 1'b0);
        check0("rst3", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst3.hold_out", 8'(if1.out), 8'd0);
        rst_n = 1'b1;
        step(1'b1, 8'h10, 1'b0);
        check0("post_rst", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
